// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Purpose: a small word-addressed data memory that answers one request at a
// time through a valid/ready request channel and a valid/ready response
// channel. Each accepted request spends WAIT_CYCLES wait states before the
// response is presented and held until the initiator takes it. Misaligned
// or out-of-range addresses are answered with an error and never touch the
// array.
//
// Parameters:
//   DEPTH        number of 16-bit words (power of two, 2..256)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset (clears FSM, outputs, array)
//   req_valid    initiator presents a request
//   req_ready    responder accepts the request this cycle (IDLE only)
//   req_we       1 = write, 0 = read
//   req_addr     byte address, word index is req_addr[15:1]
//   req_wdata    write data
//   resp_valid   response available
//   resp_ready   initiator takes the response
//   resp_rdata   read data, 0 for writes and errors
//   resp_err     request was misaligned or out of range

module data_mem_responder #(
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [3:0]    count;
    logic          ready_en;
    logic          lat_we;
    logic [15:0]   lat_addr;
    logic [15:0]   lat_wdata;
    logic [15:0]   mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          eff_we;
    logic [15:0]   eff_addr;
    logic [15:0]   eff_wdata;
    logic          eff_err;
    logic [IW-1:0] eff_idx;

    // ready_en keeps req_ready low until the first edge after reset release
    assign req_ready  = ready_en && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // With zero wait states RESP is entered on the acceptance edge itself,
    // before the latches hold the new request, so the live inputs are used.
    assign eff_we    = (state == IDLE) ? req_we    : lat_we;
    assign eff_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign eff_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign eff_err   = eff_addr[0] || ({17'd0, eff_addr[15:1]} >= 32'(DEPTH));
    assign eff_idx   = eff_addr[IW:1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (next_state == RESP) && (state != RESP);

    // Wait-state counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (accept) begin
            count <= WAIT_LOAD;
        end else if ((state == WAIT) && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // Request latches, memory array and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 16'd0;
            lat_wdata  <= 16'd0;
            resp_rdata <= 16'd0;
            resp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'd0;
            end
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (enter_resp) begin
                if (eff_err) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= 16'd0;
                end else if (eff_we) begin
                    mem[eff_idx] <= eff_wdata;
                    resp_err     <= 1'b0;
                    resp_rdata   <= 16'd0;
                end else begin
                    resp_err   <= 1'b0;
                    resp_rdata <= mem[eff_idx];
                end
            end else if ((state == RESP) && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//
// Purpose: directed self-checking bench for data_mem_responder. Instance
// dut uses DEPTH=8, WAIT_CYCLES=1; instance dut0 uses DEPTH=8,
// WAIT_CYCLES=0 with resp_ready held high. Inputs change and outputs are
// sampled on the falling clock edge.
//
// Ports: none (top-level bench).

module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;

    logic        req_valid0;
    logic        req_ready0;
    logic        req_we0;
    logic [15:0] req_addr0;
    logic [15:0] req_wdata0;
    logic        resp_valid0;
    logic        resp_ready0;
    logic [15:0] resp_rdata0;
    logic        resp_err0;

    int checks;
    int failures;

    data_mem_responder #(.DEPTH(8), .WAIT_CYCLES(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    data_mem_responder #(.DEPTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_we     (req_we0),
        .req_addr   (req_addr0),
        .req_wdata  (req_wdata0),
        .resp_valid (resp_valid0),
        .resp_ready (resp_ready0),
        .resp_rdata (resp_rdata0),
        .resp_err   (resp_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transaction on dut, entered and left on a falling edge.
    // lat counts rising edges from acceptance until the edge that samples
    // resp_valid=1.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          output int lat, output logic [15:0] rdata, output logic err);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'd0;
        req_wdata = 16'd0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h, want all 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        checks++;
        if ({req_ready0, resp_valid0, resp_err0, resp_rdata0} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs0: got rdy=%b vld=%b err=%b rdata=%h, want all 0",
                     req_ready0, resp_valid0, resp_err0, resp_rdata0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_before_edge: got %b, want 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_edge: got %b, want 1", req_ready);
        end
    endtask

    task automatic test_write_read();
        int          lat;
        logic [15:0] rd;
        logic        er;
        do_req(1'b1, 16'h0004, 16'hBEEF, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL write_0004: got lat=%0d err=%b rdata=%h, want lat=2 err=0 rdata=0000",
                     lat, er, rd);
        end
        do_req(1'b0, 16'h0004, 16'h0000, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL read_0004: got lat=%0d err=%b rdata=%h, want lat=2 err=0 rdata=beef",
                     lat, er, rd);
        end
    endtask

    task automatic test_errors();
        int          lat;
        logic [15:0] rd;
        logic        er;
        logic [15:0] model [8];
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        model[2] = 16'hBEEF;
        do_req(1'b0, 16'h0003, 16'h0000, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL misaligned_read: got err=%b rdata=%h, want err=1 rdata=0000", er, rd);
        end
        do_req(1'b1, 16'h0010, 16'hDEAD, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL range_write: got err=%b rdata=%h, want err=1 rdata=0000", er, rd);
        end
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 16'(i * 2), 16'h0000, lat, rd, er);
            checks++;
            if (er !== 1'b0 || rd !== model[i]) begin
                failures++;
                $display("[TB] FAIL word_%0d_unchanged: got err=%b rdata=%h, want err=0 rdata=%h",
                         i, er, rd, model[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [15:0] rd;
        logic        er;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0004;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_wait_state: got resp_valid=%b, want 0", resp_valid);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold_%0d: got vld=%b rdata=%h err=%b rdy=%b, want vld=1 rdata=beef err=0 rdy=0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            end
            req_valid = (i % 2 == 0);
            req_we    = 1'b1;
            req_addr  = 16'h0000;
            req_wdata = 16'h5555;
            @(negedge clk);
        end
        req_valid  = 1'b0;
        req_we     = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL bp_release: got vld=%b rdy=%b rdata=%h, want vld=0 rdy=1 rdata=0000",
                     resp_valid, req_ready, resp_rdata);
        end
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_resp_ready: got vld=%b rdy=%b, want vld=0 rdy=1", resp_valid, req_ready);
        end
        do_req(1'b0, 16'h0000, 16'h0000, lat, rd, er);
        checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_ignored_write: got rdata=%h err=%b, want rdata=0000 err=0", rd, er);
        end
    endtask

    task automatic test_boundary();
        int          lat;
        logic [15:0] rd;
        logic        er;
        do_req(1'b1, 16'h000E, 16'hCAFE, lat, rd, er);
        checks++;
        if (er !== 1'b0) begin
            failures++;
            $display("[TB] FAIL last_word_write: got err=%b, want 0", er);
        end
        do_req(1'b0, 16'h000E, 16'h0000, lat, rd, er);
        checks++;
        if (rd !== 16'hCAFE || er !== 1'b0) begin
            failures++;
            $display("[TB] FAIL last_word_read: got rdata=%h err=%b, want cafe err=0", rd, er);
        end
        do_req(1'b0, 16'h0000, 16'h0000, lat, rd, er);
        checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            failures++;
            $display("[TB] FAIL word0_untouched: got rdata=%h err=%b, want 0000 err=0", rd, er);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [15:0] rd;
        logic        er;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0002;
        req_wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: got rdy=%b vld=%b err=%b rdata=%h, want all 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset_no_resp: got vld=%b rdy=%b, want vld=0 rdy=1", resp_valid, req_ready);
        end
        do_req(1'b0, 16'h0002, 16'h0000, lat, rd, er);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL aborted_write: got rdata=%h, want 0000", rd);
        end
        do_req(1'b0, 16'h0004, 16'h0000, lat, rd, er);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL array_cleared: got rdata=%h, want 0000", rd);
        end
    endtask

    task automatic test_zero_wait();
        int resp_count;
        req_valid0 = 1'b1;
        req_we0    = 1'b1;
        req_addr0  = 16'h0006;
        req_wdata0 = 16'h1357;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        req_we0    = 1'b0;
        checks++;
        if (resp_valid0 !== 1'b1 || resp_err0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zw_write_latency: got vld=%b err=%b, want vld=1 err=0", resp_valid0, resp_err0);
        end
        @(negedge clk);
        req_valid0 = 1'b1;
        req_addr0  = 16'h0006;
        resp_count = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid0) resp_count++;
            checks++;
            if (resp_valid0 !== (k % 2 == 0) || req_ready0 !== (k % 2 == 1) ||
                resp_rdata0 !== ((k % 2 == 0) ? 16'h1357 : 16'h0000)) begin
                failures++;
                $display("[TB] FAIL zw_cycle_%0d: got vld=%b rdy=%b rdata=%h, want vld=%b rdy=%b",
                         k, resp_valid0, req_ready0, resp_rdata0, (k % 2 == 0), (k % 2 == 1));
            end
        end
        req_valid0 = 1'b0;
        checks++;
        if (resp_count !== 4) begin
            failures++;
            $display("[TB] FAIL zw_throughput: got %0d responses in 8 cycles, want 4", resp_count);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 16'd0;
        req_wdata   = 16'd0;
        resp_ready  = 1'b0;
        req_valid0  = 1'b0;
        req_we0     = 1'b0;
        req_addr0   = 16'd0;
        req_wdata0  = 16'd0;
        resp_ready0 = 1'b1;
        test_reset();
        test_write_read();
        test_errors();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
